axis_prbs_gen: RTL and testbench
================================

Name: axis_prbs_gen

Overview:
AXI4-Stream PRBS pattern source. It feeds the ALT slave input of the SDR chain's 2:1 source mux and is the on-chip test-traffic alternative to the DMA/MM2S path. It emits framed 64-bit beats (TKEEP all-ones, TLAST at the end of each frame). Pattern is PRBS7/15/23/31, advanced 64 bits per accepted beat, with software-controlled frame length and frame count.

Parameters:
AXIS_BYTES, 8, tdata width in bytes (64-bit bus); LFSR advances AXIS_BYTES*8 bits per beat
FRAME_W, 16, width of frame-length and frame-count fields

Ports:
clk  in  1  single clock domain
rst  in  1  synchronous, active-high reset
cfg_start  in  1  one-cycle pulse; starts a run from IDLE
cfg_stop  in  1  one-cycle pulse; graceful stop after current frame
cfg_poly_sel  in  2  0=PRBS7 (x^7+x^6+1), 1=PRBS15 (x^15+x^14+1), 2=PRBS23 (x^23+x^18+1), 3=PRBS31 (x^31+x^28+1)
cfg_seed  in  31  initial LFSR state, masked to polynomial length
cfg_frame_beats  in  FRAME_W  beats per frame; 0 treated as 1
cfg_num_frames  in  FRAME_W  frames per run; 0 = continuous
m_axis_tdata  out  AXIS_BYTES*8  pattern data; bit 0 = first generated bit
m_axis_tkeep  out  AXIS_BYTES  all-ones whenever tvalid
m_axis_tvalid  out  1  beat valid
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  last beat of frame
busy  out  1  high in RUN and STOPPING
done  out  1  one-cycle pulse when a run ends
frame_count  out  32  frames accepted since last start; wraps at 2^32

Behaviour:
- Reset: tvalid=0, tlast=0, tdata=0, tkeep=0, busy=0, done=0, frame_count=0; state IDLE; LFSR=0. Reset mid-run aborts immediately and drops any un-accepted beat.
- Serial LFSR model, length L, taps per cfg_poly_sel:
  - new = s[L-1]^s[tap-1]; output bit = new; s <= {s[L-2:0], new}.
  - One beat = 64 consecutive output bits, bit 0 first.
- Seed: masked to L bits; all-zero masked seed is replaced by all-ones.
- Config latching: poly, seed, frame_beats and num_frames are latched on cfg_start. Changes during a run are ignored.
- States and transitions:
  - IDLE: tvalid=0. cfg_start loads LFSR/config, clears beat counter and frame_count -> RUN. First beat is presented the cycle after start (1-cycle latency).
  - RUN: tvalid=1. tdata/tlast hold stable until accepted (tvalid & tready). On accept: advance LFSR 64 steps, increment beat counter.
    - tlast=1 exactly when beat counter == frame_beats-1. An accepted tlast clears the beat counter and increments frame_count.
    - If the accepted tlast completes num_frames (nonzero) -> IDLE, done pulse next cycle, tvalid deasserts the cycle after acceptance.
  - cfg_stop in RUN -> STOPPING. If cfg_stop arrives in the same cycle as an accepted final tlast, go directly to IDLE with one done pulse.
  - STOPPING: same as RUN, but the next accepted tlast -> IDLE with done. A frame is never truncated.
- cfg_start while busy: ignored. cfg_start and cfg_stop together in IDLE: start wins, stop ignored.
- frame_beats=1: every beat carries tlast.
- No bubble between beats while tready is held high: one beat per cycle sustained.

Optional Feature:
Macro: AXIS_PRBS_GEN_ERR_INJ_EN.
- Defined: adds input port err_inject (1 bit) and output err_count (16).
  - An err_inject pulse arms a flag. The next presented beat has tdata[0] inverted; the flag clears on acceptance of that beat.
  - err_count increments on that acceptance.
  - LFSR state is unaffected, so the checker sees exactly one bit error.
- Undefined: ports absent, data is pure PRBS.

Decomposition:
- Package axis_prbs_pkg:
  - typedef prbs_poly_e (PRBS7/15/23/31).
  - Constants for polynomial lengths and tap positions.
  - typedef state_e (IDLE, RUN, STOPPING).
  - Function prbs_len(poly).
- Sub-module prbs_lfsr_adv: combinational unrolled 64-step advance. Inputs: state, poly. Outputs: next state and 64 output bits. Instantiated once.

Test Plan:
- PRBS7, seed 0x7F, frame_beats=4, num_frames=2, tready=1 -> 8 beats; tlast on beats 3 and 7; first tdata[7:0]=0x40; all data matches bench model; done pulse once; frame_count=2.
- Random tready backpressure (50%), PRBS31, seed 0x1 -> tdata/tlast stable while stalled; sequence identical to unstalled run.
- num_frames=0, frame_beats=16, cfg_stop mid-frame at beat 5 -> frame completes to beat 15 with tlast, then IDLE and done; no extra beats.
- Seed 0x0 with PRBS15 -> behaves as seed 0x7FFF; first beat equals model with all-ones seed.
- Assert rst during RUN with tvalid high and tready low -> next cycle tvalid=0, busy=0, frame_count=0; a subsequent start replays from seed.
- (ERR_INJ_EN) err_inject pulse during stall -> exactly one accepted beat differs from model in bit 0; err_count=1; following beats match model.

Source files
------------

// File: rtl/axis_prbs_pkg.sv
// Shared types and PRBS polynomial constants for the AXI4-Stream PRBS source.
package axis_prbs_pkg;

    typedef enum logic [1:0] {
        PRBS7  = 2'd0,
        PRBS15 = 2'd1,
        PRBS23 = 2'd2,
        PRBS31 = 2'd3
    } prbs_poly_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_e;

    // Register lengths and feedback taps (x^L + x^tap + 1)
    localparam int unsigned PRBS7_LEN  = 7;
    localparam int unsigned PRBS7_TAP  = 6;
    localparam int unsigned PRBS15_LEN = 15;
    localparam int unsigned PRBS15_TAP = 14;
    localparam int unsigned PRBS23_LEN = 23;
    localparam int unsigned PRBS23_TAP = 18;
    localparam int unsigned PRBS31_LEN = 31;
    localparam int unsigned PRBS31_TAP = 28;

    function automatic int unsigned prbs_len(prbs_poly_e p);
        case (p)
            PRBS7:   return PRBS7_LEN;
            PRBS15:  return PRBS15_LEN;
            PRBS23:  return PRBS23_LEN;
            default: return PRBS31_LEN;
        endcase
    endfunction

    function automatic int unsigned prbs_tap(prbs_poly_e p);
        case (p)
            PRBS7:   return PRBS7_TAP;
            PRBS15:  return PRBS15_TAP;
            PRBS23:  return PRBS23_TAP;
            default: return PRBS31_TAP;
        endcase
    endfunction

    // Mask of the live state bits for a polynomial
    function automatic logic [30:0] prbs_mask(prbs_poly_e p);
        case (p)
            PRBS7:   return 31'h0000_007F;
            PRBS15:  return 31'h0000_7FFF;
            PRBS23:  return 31'h007F_FFFF;
            default: return 31'h7FFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/prbs_lfsr_adv.sv
// Combinational W-step advance of the serial Fibonacci LFSR.
// bits[0] is the first generated bit; next is the state after W steps.
module prbs_lfsr_adv
    import axis_prbs_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [30:0] state,
    input  prbs_poly_e  poly,
    output logic [30:0] next,
    output logic [W-1:0] bits
);

    logic [4:0]  msb;
    logic [4:0]  tap;
    logic [30:0] mask;

    assign msb  = 5'(prbs_len(poly) - 1);
    assign tap  = 5'(prbs_tap(poly) - 1);
    assign mask = prbs_mask(poly);

    // Unrolled serial steps: new = s[L-1]^s[tap-1], shifted in at bit 0
    always_comb begin
        logic [30:0] s;
        logic        nb;
        s    = state;
        nb   = 1'b0;
        bits = '0;
        for (int i = 0; i < W; i++) begin
            nb      = s[msb] ^ s[tap];
            bits[i] = nb;
            s       = {s[29:0], nb} & mask;
        end
        next = s;
    end

endmodule

// File: rtl/axis_prbs_gen.sv
// AXI4-Stream PRBS7/15/23/31 frame source with software frame length/count.
// Optional error injection on tdata[0]: define AXIS_PRBS_GEN_ERR_INJ_EN.
module axis_prbs_gen
    import axis_prbs_pkg::*;
#(
    parameter int AXIS_BYTES = 8,
    parameter int FRAME_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_start,
    input  logic                    cfg_stop,
    input  logic [1:0]              cfg_poly_sel,
    input  logic [30:0]             cfg_seed,
    input  logic [FRAME_W-1:0]      cfg_frame_beats,
    input  logic [FRAME_W-1:0]      cfg_num_frames,
    output logic [AXIS_BYTES*8-1:0] m_axis_tdata,
    output logic [AXIS_BYTES-1:0]   m_axis_tkeep,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic                    busy,
    output logic                    done,
    output logic [31:0]             frame_count
`ifdef AXIS_PRBS_GEN_ERR_INJ_EN
    ,
    input  logic                    err_inject,
    output logic [15:0]             err_count
`endif
);

    localparam int DW = AXIS_BYTES * 8;

    state_e             state, state_nx;
    prbs_poly_e         poly;
    logic [30:0]        lfsr;
    logic [30:0]        lfsr_nx;
    logic [DW-1:0]      pat;
    logic [FRAME_W-1:0] fbeats_m1;
    logic [FRAME_W-1:0] nframes;
    logic [FRAME_W-1:0] beat_cnt;
    logic               start_fire;
    logic               accept;
    logic               is_last;
    logic               last_acc;
    logic               run_done;
    logic [30:0]        seed_m;

    // lfsr holds the state before the presented beat; pat is that beat
    prbs_lfsr_adv #(.W(DW)) u_adv (
        .state (lfsr),
        .poly  (poly),
        .next  (lfsr_nx),
        .bits  (pat)
    );

    assign start_fire = (state == IDLE) && cfg_start;
    assign busy       = (state != IDLE);
    assign accept     = busy && m_axis_tready;
    assign is_last    = (beat_cnt == fbeats_m1);
    assign last_acc   = accept && is_last;
    assign run_done   = (nframes != '0) && ((frame_count + 32'd1) == 32'(nframes));
    assign seed_m     = cfg_seed & prbs_mask(prbs_poly_e'(cfg_poly_sel));

    assign m_axis_tvalid = busy;
    assign m_axis_tlast  = busy && is_last;
    assign m_axis_tkeep  = {AXIS_BYTES{busy}};

`ifdef AXIS_PRBS_GEN_ERR_INJ_EN
    logic err_armed;
    logic err_cur;
    logic beat_load;

    assign beat_load    = start_fire || (accept && (state_nx != IDLE));
    assign m_axis_tdata = busy ? (pat ^ DW'(err_cur)) : '0;

    // Armed error is attached at a beat boundary so a stalled beat never changes
    always_ff @(posedge clk) begin
        if (rst) begin
            err_armed <= 1'b0;
            err_cur   <= 1'b0;
            err_count <= '0;
        end else begin
            if (beat_load) begin
                err_cur   <= err_armed;
                err_armed <= err_inject;
            end else begin
                if (accept)     err_cur   <= 1'b0;
                if (err_inject) err_armed <= 1'b1;
            end
            if (accept && err_cur) err_count <= err_count + 16'd1;
        end
    end
`else
    assign m_axis_tdata = busy ? pat : '0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state: stop is graceful, a frame always finishes on its tlast
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (cfg_start) state_nx = RUN;
            end
            RUN: begin
                if (last_acc && (run_done || cfg_stop)) state_nx = IDLE;
                else if (cfg_stop)                      state_nx = STOPPING;
            end
            STOPPING: begin
                if (last_acc) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Config latch, LFSR advance, beat/frame counters and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            poly        <= PRBS7;
            lfsr        <= '0;
            fbeats_m1   <= '0;
            nframes     <= '0;
            beat_cnt    <= '0;
            frame_count <= '0;
            done        <= 1'b0;
        end else begin
            done <= busy && (state_nx == IDLE);
            if (start_fire) begin
                poly        <= prbs_poly_e'(cfg_poly_sel);
                lfsr        <= (seed_m == '0) ? prbs_mask(prbs_poly_e'(cfg_poly_sel)) : seed_m;
                fbeats_m1   <= (cfg_frame_beats == '0) ? '0 : cfg_frame_beats - FRAME_W'(1);
                nframes     <= cfg_num_frames;
                beat_cnt    <= '0;
                frame_count <= '0;
            end else if (accept) begin
                lfsr     <= lfsr_nx;
                beat_cnt <= is_last ? '0 : beat_cnt + FRAME_W'(1);
                if (is_last) frame_count <= frame_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_axis_prbs_gen.sv
// Self-checking bench for axis_prbs_gen against a serial bit-level PRBS model.
module tb_axis_prbs_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_start = 1'b0;
    logic        cfg_stop = 1'b0;
    logic [1:0]  cfg_poly_sel = '0;
    logic [30:0] cfg_seed = '0;
    logic [15:0] cfg_frame_beats = '0;
    logic [15:0] cfg_num_frames = '0;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        m_axis_tlast;
    logic        busy;
    logic        done;
    logic [31:0] frame_count;
`ifdef AXIS_PRBS_GEN_ERR_INJ_EN
    logic        err_inject = 1'b0;
    logic [15:0] err_count;
`endif

    axis_prbs_gen dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_start       (cfg_start),
        .cfg_stop        (cfg_stop),
        .cfg_poly_sel    (cfg_poly_sel),
        .cfg_seed        (cfg_seed),
        .cfg_frame_beats (cfg_frame_beats),
        .cfg_num_frames  (cfg_num_frames),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tkeep    (m_axis_tkeep),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .m_axis_tlast    (m_axis_tlast),
        .busy            (busy),
        .done            (done),
        .frame_count     (frame_count)
`ifdef AXIS_PRBS_GEN_ERR_INJ_EN
        ,
        .err_inject      (err_inject),
        .err_count       (err_count)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    int          LEN[4] = '{7, 15, 23, 31};
    int          TAP[4] = '{6, 14, 18, 28};
    logic [30:0] m_s;
    logic [30:0] m_mask;
    int          m_L, m_T, m_fb, m_bidx;
    logic [63:0] m_beat;

    // Run statistics
    int          n_acc, n_last, n_done, n_errb;
    logic [63:0] first_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // 64 serial steps of the textbook LFSR, bit 0 produced first
    function automatic logic [63:0] model_beat();
        logic [63:0] b;
        logic        nb;
        b = '0;
        for (int i = 0; i < 64; i++) begin
            nb   = m_s[m_L-1] ^ m_s[m_T-1];
            b[i] = nb;
            m_s  = ((m_s << 1) | 31'(nb)) & m_mask;
        end
        return b;
    endfunction

    task automatic model_start(input int poly, input logic [30:0] seed, input int fb);
        m_L    = LEN[poly];
        m_T    = TAP[poly];
        m_mask = 31'h7FFF_FFFF >> (31 - m_L);
        m_s    = seed & m_mask;
        if (m_s == '0) m_s = m_mask;
        m_fb   = (fb == 0) ? 1 : fb;
        m_bidx = 0;
        m_beat = model_beat();
    endtask

    // Pulse cfg_start (optionally with cfg_stop), then scramble config to prove it was latched
    task automatic start(input int poly, input logic [30:0] seed, input int fb, input int nf,
                         input bit with_stop);
        @(negedge clk);
        m_axis_tready   = 1'b0;
        cfg_poly_sel    = 2'(poly);
        cfg_seed        = seed;
        cfg_frame_beats = 16'(fb);
        cfg_num_frames  = 16'(nf);
        cfg_start       = 1'b1;
        cfg_stop        = with_stop;
        @(negedge clk);
        cfg_start       = 1'b0;
        cfg_stop        = 1'b0;
        cfg_poly_sel    = 2'($urandom);
        cfg_seed        = 31'($urandom);
        cfg_frame_beats = 16'($urandom_range(1, 9));
        cfg_num_frames  = 16'($urandom_range(1, 9));
        model_start(poly, seed, fb);
    endtask

    // Drive tready, check every presented beat against the model, count accepts/tlast/done
    task automatic run(input int max_cyc, input int rdy_pct, input int stop_at,
                       input bit until_done, input int inj_cyc, input bit tol_err);
        bit          stopped;
        int          post;
        bit          rdy;
        logic [63:0] obs;
        n_acc = 0; n_last = 0; n_done = 0; n_errb = 0;
        stopped = 0; post = 0; first_data = 'x;
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            @(negedge clk);
            cfg_stop = 1'b0;
            rdy = ($urandom_range(99) < rdy_pct);
`ifdef AXIS_PRBS_GEN_ERR_INJ_EN
            err_inject = 1'b0;
            if (cyc == inj_cyc) begin
                rdy        = 1'b0;
                err_inject = 1'b1;
            end
`endif
            chk("busy_eq_tvalid", busy, m_axis_tvalid);
            if (m_axis_tvalid) begin
                obs = m_axis_tdata;
                if (tol_err && ((m_axis_tdata ^ m_beat) == 64'd1)) begin
                    obs = m_axis_tdata ^ 64'd1;
                    if (rdy) n_errb++;
                end
                chk("tdata", obs, m_beat);
                chk("tlast", m_axis_tlast, (m_bidx == m_fb - 1));
                chk("tkeep", m_axis_tkeep, 8'hFF);
                if (n_acc == 0) first_data = m_axis_tdata;
                if (!stopped && stop_at >= 0 && n_acc == stop_at) begin
                    cfg_stop = 1'b1;
                    stopped  = 1;
                end
                if (rdy) begin
                    n_acc++;
                    if (m_bidx == m_fb - 1) n_last++;
                    m_bidx = (m_bidx + 1) % m_fb;
                    m_beat = model_beat();
                end
            end
            m_axis_tready = rdy;
            if (done) begin
                n_done++;
                chk("tvalid_at_done", m_axis_tvalid, 1'b0);
            end
            if (until_done && n_done > 0) begin
                post++;
                if (post > 3) break;
            end
            @(posedge clk);
        end
        if (until_done) chk("done_within_budget", (n_done > 0), 1'b1);
    endtask

    initial begin
        logic [63:0] ref_beat;
        logic [30:0] rseed;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_tlast", m_axis_tlast, 1'b0);
        chk("rst_tdata", m_axis_tdata, 64'd0);
        chk("rst_tkeep", m_axis_tkeep, 8'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_frame_count", frame_count, 32'd0);
        rst = 1'b0;

        // PRBS7 seed 0x7F, 4 beats x 2 frames, no backpressure
        start(0, 31'h7F, 4, 2, 0);
        run(60, 100, -1, 1, -1, 0);
        chk("t1_first_byte", first_data[7:0], 8'h40);
        chk("t1_beats", n_acc, 8);
        chk("t1_tlasts", n_last, 2);
        chk("t1_done_once", n_done, 1);
        chk("t1_frame_count", frame_count, 32'd2);
        chk("t1_busy_end", busy, 1'b0);

        // PRBS31 seed 1 with 50% backpressure; stall stability is covered by per-cycle tdata checks
        start(3, 31'h1, 5, 3, 0);
        run(400, 50, -1, 1, -1, 0);
        chk("t2_beats", n_acc, 15);
        chk("t2_tlasts", n_last, 3);
        chk("t2_done_once", n_done, 1);
        chk("t2_frame_count", frame_count, 32'd3);

        // Continuous run, start+stop together (start wins), graceful stop at beat 5
        start(1, 31'($urandom), 16, 0, 1);
        run(100, 100, 5, 1, -1, 0);
        chk("t3_beats", n_acc, 16);
        chk("t3_tlasts", n_last, 1);
        chk("t3_done_once", n_done, 1);
        chk("t3_frame_count", frame_count, 32'd1);

        // Zero seed on PRBS15 equals all-ones seed
        model_start(1, 31'h7FFF, 3);
        ref_beat = m_beat;
        start(1, 31'h0, 3, 1, 0);
        run(40, 70, -1, 1, -1, 0);
        chk("t4_seed0_first", first_data, ref_beat);
        chk("t4_beats", n_acc, 3);

        // frame_beats=0 behaves as 1: every beat carries tlast
        start(2, 31'($urandom), 0, 3, 0);
        run(60, 60, -1, 1, -1, 0);
        chk("t5_beats", n_acc, 3);
        chk("t5_tlasts", n_last, 3);
        chk("t5_frame_count", frame_count, 32'd3);

        // Reset mid-run while stalled, then replay from the same seed
        rseed = 31'($urandom);
        start(2, rseed, 2, 0, 0);
        run(5, 100, -1, 0, -1, 0);
        chk("t6_pre_beats", n_acc, 5);
        @(negedge clk);
        m_axis_tready = 1'b0;
        chk("t6_pre_frame_count", frame_count, 32'd2);
        chk("t6_pre_tvalid", m_axis_tvalid, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t6_rst_tvalid", m_axis_tvalid, 1'b0);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_frame_count", frame_count, 32'd0);
        chk("t6_rst_tdata", m_axis_tdata, 64'd0);
        rst = 1'b0;
        start(2, rseed, 2, 2, 0);
        run(60, 100, -1, 1, -1, 0);
        chk("t6_replay_beats", n_acc, 4);
        chk("t6_replay_frames", frame_count, 32'd2);

`ifdef AXIS_PRBS_GEN_ERR_INJ_EN
        // One injected error during a stall corrupts exactly one accepted beat in bit 0
        start(0, 31'($urandom), 6, 1, 0);
        run(60, 100, -1, 1, 2, 1);
        chk("t7_beats", n_acc, 6);
        chk("t7_err_beats", n_errb, 1);
        chk("t7_err_count", err_count, 16'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
